c64_bus_arbiter: RTL and testbench
==================================

# c64_bus_arbiter

Time-slice arbiter that shares the single-port 64 KiB system RAM between the 6502 core and the VIC-II video fetch unit. Each system cycle is split into phi1 (VIC slot) and phi2 (CPU slot). The block also implements VIC bus-steal (BA/RDY) with the 6502 three-write grace period. It sits between the CPU/VIC address-data buses and the RAM macro, and generates the CPU clock-enable that paces the core.

## Interface
- PHASE_LEN, 4, clk cycles per phase (min 3); one system cycle = 2*PHASE_LEN clks
- BA_DELAY, 3, phi2 slots the CPU keeps after BA for pending writes
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_ab  in  16  CPU address
- cpu_do  in  8  CPU write data
- cpu_we  in  1  CPU write request for current cycle
- cpu_di  out  8  CPU read data, held between captures
- cpu_ce  out  1  one-clk pulse; CPU advances one bus cycle
- cpu_rdy  out  1  6502 RDY; low stalls read cycles
- phi2  out  1  high during CPU slot
- vic_addr  in  14  VIC fetch address within bank
- vic_bank  in  2  VIC bank select (final, non-inverted)
- vic_ba_req  in  1  VIC requests phi2 slots (badline/sprite)
- vic_data  out  8  VIC fetch data
- vic_strobe  out  1  one-clk pulse; vic_data valid
- ram_addr  out  16  RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  8  RAM read data, 1-clk synchronous latency

## Operation
- Phase counter cnt 0..PHASE_LEN-1 and phase bit (0=phi1, 1=phi2); phase toggles when cnt wraps.
- Slot owner latched at cnt==0 of each phase; ram_addr driven from owner for the whole phase.
- phi1: always VIC; ram_addr = {vic_bank, vic_addr}; ram_we never asserted.
- phi2: owner per FSM. If CPU, ram_addr = cpu_ab. If VIC, ram_addr = {vic_bank, vic_addr}.
- Read capture at cnt==PHASE_LEN-1: ram_rdata goes to vic_data (with vic_strobe) or cpu_di.
- CPU write: ram_wdata = cpu_do, and ram_we is high for exactly the clk at cnt==PHASE_LEN-1 of a CPU-owned phi2 slot. cpu_di is unchanged on writes.
- cpu_ce pulses at cnt==PHASE_LEN-1 of a CPU-owned phi2 slot when cpu_we or cpu_rdy. A stalled read gives no pulse, and the CPU holds cpu_ab.
- FSM, evaluated at phi1 cnt==0, samples vic_ba_req:
  - RUN: req=1 -> BA_WAIT, ba_cnt=0, cpu_rdy=0.
  - BA_WAIT: CPU owns phi2; ba_cnt increments per phi2. ba_cnt==BA_DELAY -> VIC_OWN. req=0 -> RUN, cpu_rdy=1.
  - VIC_OWN: VIC owns phi2; no cpu_ce. req=0 -> RUN, cpu_rdy=1, and the CPU owns the next phi2.
- In BA_WAIT, CPU reads stall (rdy low) while writes complete.
- Reset mid-phase: outputs return to reset values next clk; any pending write is dropped (no ram_we).

## Timing
- Reset values:
  - cnt=0, phase=phi1, FSM=RUN, ba_cnt=0
  - phi2=0, cpu_rdy=1, cpu_ce=0, ram_we=0, vic_strobe=0
  - ram_addr=0, ram_wdata=0, cpu_di=0, vic_data=0
- The first clk after reset release is phi1 cnt==0.
- vic_strobe at clk PHASE_LEN-1 of phi1. cpu_ce/ram_we at clk 2*PHASE_LEN-1 of the system cycle.
- Read latency: address at cnt 0 -> data captured at cnt PHASE_LEN-1.
- cpu_rdy changes only at phi1 cnt==0.
- vic_ba_req changes mid-cycle are ignored until the next phi1 start.
- cpu_ce and ram_we are never both high with vic_strobe.

## Structure
- Package c64_bus_pkg holds:
  - FSM state enum (RUN, BA_WAIT, VIC_OWN)
  - slot owner enum (OWN_VIC, OWN_CPU)
  - PHI1/PHI2 phase constants
- Sub-module c64_phase_gen: counter producing phase, cnt, phase_first and phase_last strobes, and phi2.

## Test plan
- Reset, then CPU reads 0x0011 holding 0x27 -> cpu_di=0x27 and cpu_ce at clk 7 of each cycle; phi1 vic_strobe carries ram[{bank,vic_addr}].
- CPU writes 0x44 to 0x0400 -> single ram_we clk with ram_addr=0x0400, ram_wdata=0x44; cpu_di unchanged.
- vic_ba_req=1 while CPU issues 3 writes then a read:
  - cpu_rdy=0 at next phi1
  - all 3 writes complete
  - the read stalls (no cpu_ce)
  - the 4th phi2 slot goes to VIC.
- vic_ba_req=1 with CPU reading -> zero cpu_ce during BA; after 3 phi2 slots VIC owns phi2 (two vic_strobes per cycle).
- vic_bank=2, vic_addr=0x0123 -> ram_addr=0x8123 in phi1.
- reset asserted at phi2 cnt==1 of a write cycle -> no ram_we; all outputs at reset values.

Source files
------------

// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 system RAM arbiter.
package c64_bus_pkg;

  typedef enum logic [1:0] {
    RUN,
    BA_WAIT,
    VIC_OWN
  } bus_state_e;

  typedef enum logic {
    OWN_VIC,
    OWN_CPU
  } slot_owner_e;

  localparam logic PHI1 = 1'b0;
  localparam logic PHI2 = 1'b1;

endpackage

// File: rtl/c64_phase_gen.sv
// Phase counter: splits each system cycle into phi1 (VIC) and phi2 (CPU) halves.
module c64_phase_gen
  import c64_bus_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 4,
  parameter int unsigned CW        = $clog2(PHASE_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          phase,
  output logic [CW-1:0] cnt,
  output logic          phase_first,
  output logic          phase_last,
  output logic          phi2
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= PHI1;
    end else if (cnt == CW'(PHASE_LEN - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign phase_first = (cnt == '0);
  assign phase_last  = (cnt == CW'(PHASE_LEN - 1));
  assign phi2        = phase;

endmodule

// File: rtl/c64_bus_arbiter.sv
// Time-slice RAM arbiter between the 6502 core and VIC-II fetch, with BA/RDY bus steal.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 4,
  parameter int unsigned BA_DELAY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_ce,
  output logic        cpu_rdy,
  output logic        phi2,
  input  logic [13:0] vic_addr,
  input  logic [1:0]  vic_bank,
  input  logic        vic_ba_req,
  output logic [7:0]  vic_data,
  output logic        vic_strobe,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  localparam int unsigned CW = $clog2(PHASE_LEN);
  localparam int unsigned BW = (BA_DELAY > 0) ? $clog2(BA_DELAY + 1) : 1;

  logic          phase;
  logic [CW-1:0] cnt;
  logic          phase_first;
  logic          phase_last;
  logic          pre_last;
  logic          phi1_start;
  logic [15:0]   vic_full;

  bus_state_e    state;
  slot_owner_e   owner;
  logic [BW-1:0] ba_cnt;
  logic          boot;

  c64_phase_gen #(
    .PHASE_LEN(PHASE_LEN),
    .CW       (CW)
  ) u_phase_gen (
    .clk        (clk),
    .reset      (reset),
    .phase      (phase),
    .cnt        (cnt),
    .phase_first(phase_first),
    .phase_last (phase_last),
    .phi2       (phi2)
  );

  assign pre_last   = (cnt == CW'(PHASE_LEN - 2));
  assign phi1_start = phase_first && (phase == PHI1);
  assign vic_full   = {vic_bank, vic_addr};

  // Bus-steal FSM: evaluated once per system cycle at the start of phi1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      ba_cnt  <= '0;
      cpu_rdy <= 1'b1;
    end else begin
      if (phi1_start) begin
        case (state)
          RUN: begin
            if (vic_ba_req) begin
              state   <= BA_WAIT;
              ba_cnt  <= '0;
              cpu_rdy <= 1'b0;
            end
          end
          BA_WAIT: begin
            if (!vic_ba_req) begin
              state   <= RUN;
              cpu_rdy <= 1'b1;
            end else if (ba_cnt == BW'(BA_DELAY)) begin
              state <= VIC_OWN;
            end
          end
          VIC_OWN: begin
            if (!vic_ba_req) begin
              state   <= RUN;
              cpu_rdy <= 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
      if ((phase == PHI2) && phase_last && (state == BA_WAIT)) begin
        ba_cnt <= ba_cnt + 1'b1;
      end
    end
  end

  // The slot address is registered on the last clk of the preceding phase so the
  // RAM sees it from cnt 0; strobes are set one clk early so they coincide with the
  // freshly captured data. The first phi1 after reset presents the reset address,
  // so its fetch is not reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_VIC;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      cpu_ce     <= 1'b0;
      vic_strobe <= 1'b0;
      cpu_di     <= '0;
      vic_data   <= '0;
      boot       <= 1'b1;
    end else begin
      ram_we     <= 1'b0;
      cpu_ce     <= 1'b0;
      vic_strobe <= 1'b0;

      if (phase_last) begin
        boot <= 1'b0;
        if ((phase == PHI1) && (state != VIC_OWN)) begin
          owner    <= OWN_CPU;
          ram_addr <= cpu_ab;
        end else begin
          owner    <= OWN_VIC;
          ram_addr <= vic_full;
        end
      end

      if (pre_last) begin
        if (owner == OWN_VIC) begin
          if (!boot) begin
            vic_strobe <= 1'b1;
            vic_data   <= ram_rdata;
          end
        end else if (cpu_we) begin
          ram_we    <= 1'b1;
          ram_wdata <= cpu_do;
          cpu_ce    <= 1'b1;
        end else begin
          cpu_di <= ram_rdata;
          cpu_ce <= cpu_rdy;
        end
      end
    end
  end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Randomized self-checking bench for c64_bus_arbiter against a per-system-cycle model.
module tb_c64_bus_arbiter;

  localparam int P   = 4;
  localparam int BAD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_ab = '0;
  logic [7:0]  cpu_do = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_di;
  logic        cpu_ce;
  logic        cpu_rdy;
  logic        phi2;
  logic [13:0] vic_addr = '0;
  logic [1:0]  vic_bank = '0;
  logic        vic_ba_req = 1'b0;
  logic [7:0]  vic_data;
  logic        vic_strobe;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c64_bus_arbiter #(
    .PHASE_LEN(P),
    .BA_DELAY (BAD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_ab    (cpu_ab),
    .cpu_do    (cpu_do),
    .cpu_we    (cpu_we),
    .cpu_di    (cpu_di),
    .cpu_ce    (cpu_ce),
    .cpu_rdy   (cpu_rdy),
    .phi2      (phi2),
    .vic_addr  (vic_addr),
    .vic_bank  (vic_bank),
    .vic_ba_req(vic_ba_req),
    .vic_data  (vic_data),
    .vic_strobe(vic_strobe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [7:0] seed_byte(input logic [15:0] a);
    if (a == 16'h0011) return 8'h27;
    return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM macro stand-in: one-clk synchronous read, filled on the first edge.
  logic [7:0] mem [0:65535];
  bit         mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= seed_byte(16'(i));
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state, one step per system cycle.
  logic [7:0]  ref_mem [0:65535];
  bit          m_first;
  bit          m_ba;
  int          m_slots;
  bit          m_rdy;
  logic [7:0]  m_vic_data;
  logic [7:0]  m_cpu_di;
  logic [15:0] m_phi1_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_first     = 1'b1;
    m_ba        = 1'b0;
    m_slots     = 0;
    m_rdy       = 1'b1;
    m_vic_data  = '0;
    m_cpu_di    = '0;
    m_phi1_addr = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {phi2, cpu_rdy, cpu_ce, ram_we, vic_strobe, ram_addr, ram_wdata, cpu_di, vic_data},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00});
  endtask

  // Called at the negedge inside phi1 cnt 0; returns at the next cycle's phi1 cnt 0.
  task automatic run_cycle(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                           input logic [1:0] bank, input logic [13:0] vaddr, input logic req);
    bit          rdy_old;
    bit          vic_phi2;
    logic [15:0] a2;
    logic [3:0]  exp_f;
    cpu_ab     = ab;
    cpu_do     = dout;
    cpu_we     = we;
    vic_bank   = bank;
    vic_addr   = vaddr;
    vic_ba_req = req;

    rdy_old = m_rdy;
    if (!req) begin
      m_ba    = 1'b0;
      m_slots = 0;
      m_rdy   = 1'b1;
    end else if (!m_ba) begin
      m_ba    = 1'b1;
      m_slots = 0;
      m_rdy   = 1'b0;
    end
    vic_phi2 = m_ba && (m_slots >= BAD);
    a2 = vic_phi2 ? {bank, vaddr} : ab;

    for (int j = 0; j < 2 * P; j++) begin
      exp_f[3] = (j >= P);
      exp_f[2] = ((j == P - 1) && !m_first) || ((j == 2 * P - 1) && vic_phi2);
      exp_f[1] = (j == 2 * P - 1) && !vic_phi2 && (we || m_rdy);
      exp_f[0] = (j == 2 * P - 1) && !vic_phi2 && we;
      if ((j == P - 1) && !m_first) m_vic_data = ref_mem[m_phi1_addr];
      if (j == 2 * P - 1) begin
        if (vic_phi2) m_vic_data = ref_mem[a2];
        else if (!we) m_cpu_di = ref_mem[a2];
      end
      check("phi2/strobe/ce/we", {phi2, vic_strobe, cpu_ce, ram_we}, exp_f);
      check("cpu_rdy", cpu_rdy, (j == 0) ? rdy_old : m_rdy);
      check("ram_addr", ram_addr, (j < P) ? m_phi1_addr : a2);
      check("vic_data", vic_data, m_vic_data);
      check("cpu_di", cpu_di, m_cpu_di);
      if ((j == 2 * P - 1) && we && !vic_phi2) check("ram_wdata", ram_wdata, dout);
      @(negedge clk);
    end

    if (!vic_phi2 && we) ref_mem[ab] = dout;
    if (m_ba && !vic_phi2) m_slots++;
    m_phi1_addr = {bank, vaddr};
    m_first     = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rnd_req;
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(16'(i));
    model_reset();

    @(negedge clk);
    check_reset_vals("reset_state");
    @(negedge clk);
    check_reset_vals("reset_state_hold");
    reset = 1'b0;

    // Plain reads, then write and read-back.
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd0, 14'h0020, 1'b0);
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd0, 14'h0021, 1'b0);
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd0, 14'h0022, 1'b0);
    check("cpu_di_0011", cpu_di, 8'h27);
    run_cycle(16'h0400, 8'h44, 1'b1, 2'd0, 14'h0400, 1'b0);
    check("cpu_di_kept_on_write", cpu_di, 8'h27);
    run_cycle(16'h0400, 8'h00, 1'b0, 2'd0, 14'h0023, 1'b0);
    check("readback_0400", cpu_di, 8'h44);

    // Bank select.
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd2, 14'h0123, 1'b0);
    check("bank_addr", ram_addr, 16'h8123);
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd2, 14'h0123, 1'b0);

    // BA during three writes then a read.
    run_cycle(16'h0500, 8'h11, 1'b1, 2'd0, 14'h0500, 1'b1);
    run_cycle(16'h0501, 8'h22, 1'b1, 2'd0, 14'h0501, 1'b1);
    run_cycle(16'h0502, 8'h33, 1'b1, 2'd0, 14'h0502, 1'b1);
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd0, 14'h0500, 1'b1);
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd0, 14'h0501, 1'b1);
    run_cycle(16'h0011, 8'h00, 1'b0, 2'd0, 14'h0502, 1'b0);

    // BA while reading.
    for (int n = 0; n < 5; n++) run_cycle(16'h0502, 8'h00, 1'b0, 2'd1, 14'(n), 1'b1);
    run_cycle(16'h0502, 8'h00, 1'b0, 2'd0, 14'h0010, 1'b0);
    check("read_after_ba", cpu_di, 8'h33);
    run_cycle(16'h0400, 8'h00, 1'b0, 2'd0, 14'h0011, 1'b0);

    // Random traffic with sticky BA requests.
    rnd_req = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  bk;
      logic [13:0] va;
      if ($urandom_range(0, 5) == 0) rnd_req = ~rnd_req;
      if ($urandom_range(0, 1) == 0) begin
        bk = 2'd0;
        va = 14'h0400 + 14'($urandom_range(0, 31));
      end else begin
        bk = 2'($urandom);
        va = 14'($urandom);
      end
      run_cycle(16'h0400 + 16'($urandom_range(0, 31)), 8'($urandom),
                ($urandom_range(0, 2) == 0), bk, va, rnd_req);
    end
    run_cycle(16'h0400, 8'h00, 1'b0, 2'd0, 14'h0000, 1'b0);

    // Reset at phi2 cnt 1 of a write cycle: the write must be dropped.
    cpu_ab = 16'h0410; cpu_do = 8'hA5; cpu_we = 1'b1;
    vic_ba_req = 1'b0; vic_bank = 2'd0; vic_addr = 14'h0410;
    for (int j = 0; j < P + 1; j++) begin
      check("pre_reset_no_we", ram_we, 1'b0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset_state");
    @(negedge clk);
    check_reset_vals("mid_reset_hold");
    reset = 1'b0;
    model_reset();
    run_cycle(16'h0410, 8'h00, 1'b0, 2'd0, 14'h0410, 1'b0);
    run_cycle(16'h0410, 8'h00, 1'b0, 2'd0, 14'h0411, 1'b0);
    check("dropped_write", cpu_di, ref_mem[16'h0410]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
